// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one outstanding read at a time to instruction
// memory, queues returned {pc, instruction} pairs for decode, and stalls the PC.
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              pc_valid,
   input  logic              flush,
   output logic              pc_stall,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata,
   output logic [31:0]       instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [1:0]        state;
   logic [1:0]        next_state;
   logic [ADDR_W-1:0] req_pc;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [31:0]       data_mem [DEPTH];

   logic launch;
   logic push;
   logic pop;

   assign launch = (state == IDLE) && pc_valid && !flush && (count < FULL_CNT);
   assign push   = (state == REQ) && !mem_waitrequest && !flush;
   assign pop    = instr_valid && instr_ready;

   assign mem_read    = (state != IDLE);
   assign mem_address = mem_read ? req_pc : '0;

   // The PC advances on a clean completion or loads its target on a redirect;
   // reset overrides both so the PC sees a hold while it is being reset.
   assign pc_stall = !rst || !(push || flush);

   assign instr_valid = (count != '0);
   assign instr_out   = instr_valid ? data_mem[rd_ptr] : '0;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

   // A request that has been issued is never withdrawn; a flush while memory is
   // stalling parks in DROP until the read completes and its data is discarded.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (launch) next_state = REQ;
         REQ: begin
            if (!mem_waitrequest)
               next_state = IDLE;
            else if (flush)
               next_state = DROP;
         end
         DROP: if (!mem_waitrequest) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         req_pc <= '0;
      end else begin
         state <= next_state;
         if (launch)
            req_pc <= pc_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= req_pc;
         data_mem[wr_ptr] <= mem_readdata;
      end
   end

endmodule
